// File: rtl/host_mem_rdwr_arbiter.sv
// Two-requester (dma/krn) arbiter for the host-memory Avalon-MM read/write channel with
// weighted round-robin grant and in-order response routing. Optional counters: HOST_MEM_ARB_PERF_CNT_EN.

module host_mem_arb_trk #(
    parameter int W     = 8,
    parameter int DEPTH = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic [W-1:0]  r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rp];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end
endmodule

module host_mem_rdwr_arbiter #(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int DMA_WEIGHT      = 4,
    parameter int KRN_WEIGHT      = 1,
    parameter int RD_TRACK_DEPTH  = 64,
    parameter int WR_TRACK_DEPTH  = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    // dma read
    input  logic [ADDR_WIDTH-1:0]      i_dma_rd_address,
    input  logic [BURST_CNT_WIDTH-1:0] i_dma_rd_burstcount,
    input  logic                       i_dma_rd_read,
    output logic                       o_dma_rd_waitrequest,
    output logic [DATA_WIDTH-1:0]      o_dma_rd_readdata,
    output logic                       o_dma_rd_readdatavalid,
    // krn read
    input  logic [ADDR_WIDTH-1:0]      i_krn_rd_address,
    input  logic [BURST_CNT_WIDTH-1:0] i_krn_rd_burstcount,
    input  logic                       i_krn_rd_read,
    output logic                       o_krn_rd_waitrequest,
    output logic [DATA_WIDTH-1:0]      o_krn_rd_readdata,
    output logic                       o_krn_rd_readdatavalid,
    // mem read
    output logic [ADDR_WIDTH-1:0]      o_mem_rd_address,
    output logic [BURST_CNT_WIDTH-1:0] o_mem_rd_burstcount,
    output logic                       o_mem_rd_read,
    input  logic                       i_mem_rd_waitrequest,
    input  logic [DATA_WIDTH-1:0]      i_mem_rd_readdata,
    input  logic                       i_mem_rd_readdatavalid,
    // dma write
    input  logic [ADDR_WIDTH-1:0]      i_dma_wr_address,
    input  logic [BURST_CNT_WIDTH-1:0] i_dma_wr_burstcount,
    input  logic                       i_dma_wr_write,
    input  logic [DATA_WIDTH-1:0]      i_dma_wr_writedata,
    input  logic [DATA_WIDTH/8-1:0]    i_dma_wr_byteenable,
    output logic                       o_dma_wr_waitrequest,
    output logic                       o_dma_wr_writeresponsevalid,
    // krn write
    input  logic [ADDR_WIDTH-1:0]      i_krn_wr_address,
    input  logic [BURST_CNT_WIDTH-1:0] i_krn_wr_burstcount,
    input  logic                       i_krn_wr_write,
    input  logic [DATA_WIDTH-1:0]      i_krn_wr_writedata,
    input  logic [DATA_WIDTH/8-1:0]    i_krn_wr_byteenable,
    output logic                       o_krn_wr_waitrequest,
    output logic                       o_krn_wr_writeresponsevalid,
    // mem write
    output logic [ADDR_WIDTH-1:0]      o_mem_wr_address,
    output logic [BURST_CNT_WIDTH-1:0] o_mem_wr_burstcount,
    output logic                       o_mem_wr_write,
    output logic [DATA_WIDTH-1:0]      o_mem_wr_writedata,
    output logic [DATA_WIDTH/8-1:0]    o_mem_wr_byteenable,
    input  logic                       i_mem_wr_waitrequest,
    input  logic                       i_mem_wr_writeresponsevalid,
`ifdef HOST_MEM_ARB_PERF_CNT_EN
    output logic [31:0]                o_dma_rd_grant_cnt,
    output logic [31:0]                o_krn_rd_grant_cnt,
    output logic [31:0]                o_dma_wr_grant_cnt,
    output logic [31:0]                o_krn_wr_grant_cnt,
    output logic [31:0]                o_dma_stall_cnt,
    output logic [31:0]                o_krn_stall_cnt,
`endif
    output logic                       o_err_orphan_rsp
);
    localparam int WCW = 16;
    localparam int BCW = BURST_CNT_WIDTH;
    localparam logic [WCW-1:0] DMA_W = WCW'(DMA_WEIGHT);
    localparam logic [WCW-1:0] KRN_W = WCW'(KRN_WEIGHT);

    typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;

    // read arbitration: grant id 0 = dma, 1 = krn
    logic           r_rd_gnt;
    logic [WCW-1:0] r_rd_cnt;
    logic           w_rd_sel;
    logic           w_rd_own_req;
    logic           w_rd_oth_req;
    logic [WCW-1:0] w_rd_own_w;
    logic [WCW-1:0] w_rd_sel_w;
    logic           w_rd_sel_read;
    logic           w_rd_acc;
    logic           w_rd_full;
    logic           w_rd_empty;
    logic [BCW:0]   w_rd_head;
    logic [BCW-1:0] r_rd_beat;
    logic           w_rd_rdv;
    logic           w_rd_last;
    logic           w_rd_pop;

    always_comb begin
        w_rd_own_req = r_rd_gnt ? i_krn_rd_read : i_dma_rd_read;
        w_rd_oth_req = r_rd_gnt ? i_dma_rd_read : i_krn_rd_read;
        w_rd_own_w   = r_rd_gnt ? KRN_W : DMA_W;
        w_rd_sel     = r_rd_gnt;
        if (!(w_rd_own_req && (r_rd_cnt < w_rd_own_w)) && w_rd_oth_req)
            w_rd_sel = ~r_rd_gnt;
    end

    assign w_rd_sel_w    = w_rd_sel ? KRN_W : DMA_W;
    assign w_rd_sel_read = w_rd_sel ? i_krn_rd_read : i_dma_rd_read;
    assign o_mem_rd_read = i_rst_n & w_rd_sel_read & ~w_rd_full;
    assign w_rd_acc      = o_mem_rd_read & ~i_mem_rd_waitrequest;
    assign o_mem_rd_address    = w_rd_sel ? i_krn_rd_address : i_dma_rd_address;
    assign o_mem_rd_burstcount = w_rd_sel ? i_krn_rd_burstcount : i_dma_rd_burstcount;
    assign o_dma_rd_waitrequest = ~i_rst_n | w_rd_sel | i_mem_rd_waitrequest | w_rd_full;
    assign o_krn_rd_waitrequest = ~i_rst_n | ~w_rd_sel | i_mem_rd_waitrequest | w_rd_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_gnt <= 1'b0;
            r_rd_cnt <= '0;
        end else begin
            r_rd_gnt <= w_rd_sel;
            if (w_rd_sel != r_rd_gnt)
                r_rd_cnt <= w_rd_acc ? WCW'(1) : '0;
            else if (w_rd_acc && (r_rd_cnt < w_rd_sel_w))
                r_rd_cnt <= r_rd_cnt + WCW'(1);
        end
    end

    host_mem_arb_trk #(.W(BCW+1), .DEPTH(RD_TRACK_DEPTH)) u_rd_trk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_rd_acc),
        .i_pop   (w_rd_pop),
        .i_din   ({w_rd_sel, o_mem_rd_burstcount}),
        .o_dout  (w_rd_head),
        .o_empty (w_rd_empty),
        .o_full  (w_rd_full)
    );

    assign w_rd_rdv  = i_rst_n & i_mem_rd_readdatavalid & ~w_rd_empty;
    assign w_rd_last = ((r_rd_beat + BCW'(1)) == w_rd_head[BCW-1:0]);
    assign w_rd_pop  = w_rd_rdv & w_rd_last;
    assign o_dma_rd_readdata      = i_mem_rd_readdata;
    assign o_krn_rd_readdata      = i_mem_rd_readdata;
    assign o_dma_rd_readdatavalid = w_rd_rdv & ~w_rd_head[BCW];
    assign o_krn_rd_readdatavalid = w_rd_rdv & w_rd_head[BCW];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_rd_beat <= '0;
        else if (w_rd_rdv)
            r_rd_beat <= w_rd_last ? '0 : r_rd_beat + BCW'(1);
    end

    // write arbitration: grant re-evaluated only between bursts
    wr_state_t      r_wr_state;
    wr_state_t      w_wr_state_nxt;
    logic           r_wr_gnt;
    logic [WCW-1:0] r_wr_cnt;
    logic [BCW-1:0] r_wr_left;
    logic           w_wr_sel;
    logic           w_wr_own_req;
    logic           w_wr_oth_req;
    logic [WCW-1:0] w_wr_own_w;
    logic [WCW-1:0] w_wr_sel_w;
    logic           w_wr_sel_write;
    logic           w_wr_acc;
    logic           w_wr_first;
    logic           w_wr_full;
    logic           w_wr_empty;
    logic           w_wr_head;
    logic           w_wr_rsp;

    always_comb begin
        w_wr_own_req = r_wr_gnt ? i_krn_wr_write : i_dma_wr_write;
        w_wr_oth_req = r_wr_gnt ? i_dma_wr_write : i_krn_wr_write;
        w_wr_own_w   = r_wr_gnt ? KRN_W : DMA_W;
        w_wr_sel     = r_wr_gnt;
        if ((r_wr_state == WR_IDLE) && !(w_wr_own_req && (r_wr_cnt < w_wr_own_w)) && w_wr_oth_req)
            w_wr_sel = ~r_wr_gnt;
    end

    assign w_wr_sel_w     = w_wr_sel ? KRN_W : DMA_W;
    assign w_wr_sel_write = w_wr_sel ? i_krn_wr_write : i_dma_wr_write;
    // tracker-full only holds off the first beat; an open burst always completes
    assign o_mem_wr_write = i_rst_n & w_wr_sel_write & ((r_wr_state == WR_BURST) | ~w_wr_full);
    assign w_wr_acc       = o_mem_wr_write & ~i_mem_wr_waitrequest;
    assign w_wr_first     = w_wr_acc & (r_wr_state == WR_IDLE);
    assign o_mem_wr_address    = w_wr_sel ? i_krn_wr_address : i_dma_wr_address;
    assign o_mem_wr_burstcount = w_wr_sel ? i_krn_wr_burstcount : i_dma_wr_burstcount;
    assign o_mem_wr_writedata  = w_wr_sel ? i_krn_wr_writedata : i_dma_wr_writedata;
    assign o_mem_wr_byteenable = w_wr_sel ? i_krn_wr_byteenable : i_dma_wr_byteenable;
    assign o_dma_wr_waitrequest = ~i_rst_n | w_wr_sel | i_mem_wr_waitrequest
                                | ((r_wr_state == WR_IDLE) & w_wr_full);
    assign o_krn_wr_waitrequest = ~i_rst_n | ~w_wr_sel | i_mem_wr_waitrequest
                                | ((r_wr_state == WR_IDLE) & w_wr_full);

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            WR_IDLE:  if (w_wr_acc && (o_mem_wr_burstcount != BCW'(1))) w_wr_state_nxt = WR_BURST;
            WR_BURST: if (w_wr_acc && (r_wr_left == BCW'(1)))           w_wr_state_nxt = WR_IDLE;
            default:  w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_state <= WR_IDLE;
            r_wr_gnt   <= 1'b0;
            r_wr_cnt   <= '0;
            r_wr_left  <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if (r_wr_state == WR_IDLE) begin
                r_wr_gnt <= w_wr_sel;
                if (w_wr_sel != r_wr_gnt)
                    r_wr_cnt <= w_wr_first ? WCW'(1) : '0;
                else if (w_wr_first && (r_wr_cnt < w_wr_sel_w))
                    r_wr_cnt <= r_wr_cnt + WCW'(1);
                if (w_wr_first)
                    r_wr_left <= o_mem_wr_burstcount - BCW'(1);
            end else if (w_wr_acc) begin
                r_wr_left <= r_wr_left - BCW'(1);
            end
        end
    end

    host_mem_arb_trk #(.W(1), .DEPTH(WR_TRACK_DEPTH)) u_wr_trk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_wr_first),
        .i_pop   (w_wr_rsp),
        .i_din   (w_wr_sel),
        .o_dout  (w_wr_head),
        .o_empty (w_wr_empty),
        .o_full  (w_wr_full)
    );

    assign w_wr_rsp = i_rst_n & i_mem_wr_writeresponsevalid & ~w_wr_empty;
    assign o_dma_wr_writeresponsevalid = w_wr_rsp & ~w_wr_head;
    assign o_krn_wr_writeresponsevalid = w_wr_rsp & w_wr_head;

    logic r_err;
    assign o_err_orphan_rsp = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_err <= 1'b0;
        else if ((i_mem_rd_readdatavalid && w_rd_empty) || (i_mem_wr_writeresponsevalid && w_wr_empty))
            r_err <= 1'b1;
    end

`ifdef HOST_MEM_ARB_PERF_CNT_EN
    logic [31:0] r_dma_rd_gcnt, r_krn_rd_gcnt, r_dma_wr_gcnt, r_krn_wr_gcnt;
    logic [31:0] r_dma_stall, r_krn_stall;
    logic        w_dma_stall, w_krn_stall;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    assign w_dma_stall = (i_dma_rd_read & o_dma_rd_waitrequest) | (i_dma_wr_write & o_dma_wr_waitrequest);
    assign w_krn_stall = (i_krn_rd_read & o_krn_rd_waitrequest) | (i_krn_wr_write & o_krn_wr_waitrequest);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dma_rd_gcnt <= '0;
            r_krn_rd_gcnt <= '0;
            r_dma_wr_gcnt <= '0;
            r_krn_wr_gcnt <= '0;
            r_dma_stall   <= '0;
            r_krn_stall   <= '0;
        end else begin
            r_dma_rd_gcnt <= sat_inc(r_dma_rd_gcnt, w_rd_acc & ~w_rd_sel);
            r_krn_rd_gcnt <= sat_inc(r_krn_rd_gcnt, w_rd_acc & w_rd_sel);
            r_dma_wr_gcnt <= sat_inc(r_dma_wr_gcnt, w_wr_first & ~w_wr_sel);
            r_krn_wr_gcnt <= sat_inc(r_krn_wr_gcnt, w_wr_first & w_wr_sel);
            r_dma_stall   <= sat_inc(r_dma_stall, w_dma_stall);
            r_krn_stall   <= sat_inc(r_krn_stall, w_krn_stall);
        end
    end

    assign o_dma_rd_grant_cnt = r_dma_rd_gcnt;
    assign o_krn_rd_grant_cnt = r_krn_rd_gcnt;
    assign o_dma_wr_grant_cnt = r_dma_wr_gcnt;
    assign o_krn_wr_grant_cnt = r_krn_wr_gcnt;
    assign o_dma_stall_cnt    = r_dma_stall;
    assign o_krn_stall_cnt    = r_krn_stall;
`endif
endmodule

// File: tb/tb_host_mem_rdwr_arbiter.sv
// Directed bench for host_mem_rdwr_arbiter: arbitration pattern, response routing,
// write burst locking, tracker full, reset and orphan responses.

module tb_host_mem_rdwr_arbiter;
    localparam int AW = 48;
    localparam int DW = 512;
    localparam int BW = 7;
    localparam logic [AW-1:0] DMA_RA = 48'h0000_1000_0000;
    localparam logic [AW-1:0] KRN_RA = 48'h0000_2000_0000;
    localparam logic [AW-1:0] DMA_WA = 48'h0000_3000_0000;
    localparam logic [AW-1:0] KRN_WA = 48'h0000_4000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] dma_rd_address, krn_rd_address;
    logic [BW-1:0] dma_rd_bc, krn_rd_bc;
    logic dma_rd_read, krn_rd_read;
    logic dma_rd_wait, krn_rd_wait;
    logic [DW-1:0] dma_rd_data, krn_rd_data;
    logic dma_rd_rdv, krn_rd_rdv;
    logic [AW-1:0] mem_rd_address;
    logic [BW-1:0] mem_rd_bc;
    logic mem_rd_read, mem_rd_wait;
    logic [DW-1:0] mem_rd_data;
    logic mem_rd_rdv;
    logic [AW-1:0] dma_wr_address, krn_wr_address;
    logic [BW-1:0] dma_wr_bc, krn_wr_bc;
    logic dma_wr_write, krn_wr_write;
    logic [DW-1:0] dma_wr_data, krn_wr_data;
    logic [DW/8-1:0] dma_wr_be, krn_wr_be;
    logic dma_wr_wait, krn_wr_wait, dma_wr_rsp, krn_wr_rsp;
    logic [AW-1:0] mem_wr_address;
    logic [BW-1:0] mem_wr_bc;
    logic mem_wr_write;
    logic [DW-1:0] mem_wr_data;
    logic [DW/8-1:0] mem_wr_be;
    logic mem_wr_wait, mem_wr_rsp;
    logic err;
`ifdef HOST_MEM_ARB_PERF_CNT_EN
    logic [31:0] dma_rd_gc, krn_rd_gc, dma_wr_gc, krn_wr_gc, dma_stall, krn_stall;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    host_mem_rdwr_arbiter dut (
        .i_clk                       (clk),
        .i_rst_n                     (rst_n),
        .i_dma_rd_address            (dma_rd_address),
        .i_dma_rd_burstcount         (dma_rd_bc),
        .i_dma_rd_read               (dma_rd_read),
        .o_dma_rd_waitrequest        (dma_rd_wait),
        .o_dma_rd_readdata           (dma_rd_data),
        .o_dma_rd_readdatavalid      (dma_rd_rdv),
        .i_krn_rd_address            (krn_rd_address),
        .i_krn_rd_burstcount         (krn_rd_bc),
        .i_krn_rd_read               (krn_rd_read),
        .o_krn_rd_waitrequest        (krn_rd_wait),
        .o_krn_rd_readdata           (krn_rd_data),
        .o_krn_rd_readdatavalid      (krn_rd_rdv),
        .o_mem_rd_address            (mem_rd_address),
        .o_mem_rd_burstcount         (mem_rd_bc),
        .o_mem_rd_read               (mem_rd_read),
        .i_mem_rd_waitrequest        (mem_rd_wait),
        .i_mem_rd_readdata           (mem_rd_data),
        .i_mem_rd_readdatavalid      (mem_rd_rdv),
        .i_dma_wr_address            (dma_wr_address),
        .i_dma_wr_burstcount         (dma_wr_bc),
        .i_dma_wr_write              (dma_wr_write),
        .i_dma_wr_writedata          (dma_wr_data),
        .i_dma_wr_byteenable         (dma_wr_be),
        .o_dma_wr_waitrequest        (dma_wr_wait),
        .o_dma_wr_writeresponsevalid (dma_wr_rsp),
        .i_krn_wr_address            (krn_wr_address),
        .i_krn_wr_burstcount         (krn_wr_bc),
        .i_krn_wr_write              (krn_wr_write),
        .i_krn_wr_writedata          (krn_wr_data),
        .i_krn_wr_byteenable         (krn_wr_be),
        .o_krn_wr_waitrequest        (krn_wr_wait),
        .o_krn_wr_writeresponsevalid (krn_wr_rsp),
        .o_mem_wr_address            (mem_wr_address),
        .o_mem_wr_burstcount         (mem_wr_bc),
        .o_mem_wr_write              (mem_wr_write),
        .o_mem_wr_writedata          (mem_wr_data),
        .o_mem_wr_byteenable         (mem_wr_be),
        .i_mem_wr_waitrequest        (mem_wr_wait),
        .i_mem_wr_writeresponsevalid (mem_wr_rsp),
`ifdef HOST_MEM_ARB_PERF_CNT_EN
        .o_dma_rd_grant_cnt          (dma_rd_gc),
        .o_krn_rd_grant_cnt          (krn_rd_gc),
        .o_dma_wr_grant_cnt          (dma_wr_gc),
        .o_krn_wr_grant_cnt          (krn_wr_gc),
        .o_dma_stall_cnt             (dma_stall),
        .o_krn_stall_cnt             (krn_stall),
`endif
        .o_err_orphan_rsp            (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int k;
        logic wt;
        rst_n = 1'b0;
        dma_rd_address = DMA_RA; krn_rd_address = KRN_RA;
        dma_rd_bc = 7'd1; krn_rd_bc = 7'd1;
        dma_rd_read = 1'b0; krn_rd_read = 1'b0;
        mem_rd_wait = 1'b0; mem_rd_data = '0; mem_rd_rdv = 1'b0;
        dma_wr_address = DMA_WA; krn_wr_address = KRN_WA;
        dma_wr_bc = 7'd16; krn_wr_bc = 7'd2;
        dma_wr_write = 1'b0; krn_wr_write = 1'b0;
        dma_wr_data = '0; krn_wr_data = '0;
        dma_wr_be = '1; krn_wr_be = '1;
        mem_wr_wait = 1'b0; mem_wr_rsp = 1'b0;

        // reset values with requests already pending
        repeat (2) @(negedge clk);
        dma_rd_read = 1'b1; dma_wr_write = 1'b1;
        #1;
        chk("rst_dma_rd_wait", 64'(dma_rd_wait), 64'd1);
        chk("rst_krn_rd_wait", 64'(krn_rd_wait), 64'd1);
        chk("rst_dma_wr_wait", 64'(dma_wr_wait), 64'd1);
        chk("rst_krn_wr_wait", 64'(krn_wr_wait), 64'd1);
        chk("rst_mem_rd_read", 64'(mem_rd_read), 64'd0);
        chk("rst_mem_wr_write", 64'(mem_wr_write), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        dma_wr_write = 1'b0;

        // 1: continuous 1-beat reads from both -> dma x4, krn x1
        @(negedge clk);
        rst_n = 1'b1; dma_rd_read = 1'b1; krn_rd_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk("t1_mem_rd_read", 64'(mem_rd_read), 64'd1);
            chk("t1_rr_addr", 64'(mem_rd_address), 64'((i % 5 == 4) ? KRN_RA : DMA_RA));
        end
        @(negedge clk);
        dma_rd_read = 1'b0; krn_rd_read = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            mem_rd_rdv = 1'b1; mem_rd_data = DW'(i + 1);
            #1;
            chk("t1_dma_rdv", 64'(dma_rd_rdv), (i % 5 == 4) ? 64'd0 : 64'd1);
            chk("t1_krn_rdv", 64'(krn_rd_rdv), (i % 5 == 4) ? 64'd1 : 64'd0);
        end

        // 2: dma burst 8 then krn burst 2, data returned back-to-back
        @(negedge clk);
        mem_rd_rdv = 1'b0;
        dma_rd_read = 1'b1; dma_rd_bc = 7'd8;
        #1;
        chk("t2_dma_bc", 64'(mem_rd_bc), 64'd8);
        chk("t2_dma_addr", 64'(mem_rd_address), 64'(DMA_RA));
        @(negedge clk);
        dma_rd_read = 1'b0; krn_rd_read = 1'b1; krn_rd_bc = 7'd2;
        #1;
        chk("t2_krn_bc", 64'(mem_rd_bc), 64'd2);
        chk("t2_krn_addr", 64'(mem_rd_address), 64'(KRN_RA));
        chk("t2_krn_wait", 64'(krn_rd_wait), 64'd0);
        @(negedge clk);
        krn_rd_read = 1'b0; krn_rd_bc = 7'd1; dma_rd_bc = 7'd1;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            mem_rd_rdv = 1'b1; mem_rd_data = DW'(16'h50 + i);
            #1;
            chk("t2_dma_rdv", 64'(dma_rd_rdv), (i < 8) ? 64'd1 : 64'd0);
            chk("t2_krn_rdv", 64'(krn_rd_rdv), (i < 8) ? 64'd0 : 64'd1);
            chk("t2_rdata", (i < 8) ? dma_rd_data[63:0] : krn_rd_data[63:0], 64'(16'h50 + i));
        end

        // 4: krn fills the read tracker with 64 outstanding reads
        @(negedge clk);
        mem_rd_rdv = 1'b0;
        krn_rd_read = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk("t4_fill_wait", 64'(krn_rd_wait), 64'd0);
        end
        @(negedge clk); #1;
        chk("t4_full_wait", 64'(krn_rd_wait), 64'd1);
        chk("t4_full_noread", 64'(mem_rd_read), 64'd0);
        @(negedge clk); #1;
        chk("t4_full_wait2", 64'(krn_rd_wait), 64'd1);
        @(negedge clk);
        mem_rd_rdv = 1'b1;
        #1;
        chk("t4_pop_rdv", 64'(krn_rd_rdv), 64'd1);
        chk("t4_pop_cycle_wait", 64'(krn_rd_wait), 64'd1);
        @(negedge clk);
        mem_rd_rdv = 1'b0;
        #1;
        chk("t4_after_pop_wait", 64'(krn_rd_wait), 64'd0);
        @(negedge clk);
        krn_rd_read = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i != 0) @(negedge clk);
            mem_rd_rdv = 1'b1;
            #1;
            chk("t4_drain_rdv", 64'(krn_rd_rdv), 64'd1);
        end

        // 3: dma write burst 16 with krn pending, toggling mem waitrequest
        @(negedge clk);
        mem_rd_rdv = 1'b0;
        dma_wr_write = 1'b1; krn_wr_write = 1'b1;
        krn_wr_data = DW'(16'h2000);
        k = 0;
        for (int c = 0; c < 32; c++) begin
            if (c != 0) @(negedge clk);
            wt = (c % 2 == 0);
            mem_wr_wait = wt;
            dma_wr_data = DW'(16'h1000 + k);
            #1;
            chk("t3_mem_write", 64'(mem_wr_write), 64'd1);
            chk("t3_dma_beat", mem_wr_data[63:0], 64'(16'h1000 + k));
            chk("t3_krn_held", 64'(krn_wr_wait), 64'd1);
            if (!wt) k++;
        end
        @(negedge clk);
        dma_wr_write = 1'b0; mem_wr_wait = 1'b0;
        #1;
        chk("t3_krn_addr", 64'(mem_wr_address), 64'(KRN_WA));
        chk("t3_krn_beat0", mem_wr_data[63:0], 64'h2000);
        chk("t3_krn_wait0", 64'(krn_wr_wait), 64'd0);
        @(negedge clk);
        krn_wr_data = DW'(16'h2001);
        #1;
        chk("t3_krn_beat1", mem_wr_data[63:0], 64'h2001);
        chk("t3_krn_wait1", 64'(krn_wr_wait), 64'd0);
        @(negedge clk);
        krn_wr_write = 1'b0;
        #1;
        chk("t3_wr_idle", 64'(mem_wr_write), 64'd0);
        @(negedge clk);
        mem_wr_rsp = 1'b1;
        #1;
        chk("t3_rsp1_dma", 64'(dma_wr_rsp), 64'd1);
        chk("t3_rsp1_krn", 64'(krn_wr_rsp), 64'd0);
        @(negedge clk); #1;
        chk("t3_rsp2_dma", 64'(dma_wr_rsp), 64'd0);
        chk("t3_rsp2_krn", 64'(krn_wr_rsp), 64'd1);

        // 5: reset with 3 reads outstanding, then a stray beat
        @(negedge clk);
        mem_wr_rsp = 1'b0;
        dma_rd_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk("t5_issue", 64'(mem_rd_read), 64'd1);
        end
        @(negedge clk);
        dma_rd_read = 1'b0;
        #1;
        chk("t5_err_pre", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b0; dma_rd_read = 1'b1; krn_wr_write = 1'b1;
        #1;
        chk("t5_rst_dma_rd_wait", 64'(dma_rd_wait), 64'd1);
        chk("t5_rst_krn_wr_wait", 64'(krn_wr_wait), 64'd1);
        chk("t5_rst_mem_rd_read", 64'(mem_rd_read), 64'd0);
        chk("t5_rst_mem_wr_write", 64'(mem_wr_write), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; dma_rd_read = 1'b0; krn_wr_write = 1'b0;
        mem_rd_rdv = 1'b1;
        #1;
        chk("t5_stray_dma_rdv", 64'(dma_rd_rdv), 64'd0);
        chk("t5_stray_krn_rdv", 64'(krn_rd_rdv), 64'd0);
        @(negedge clk);
        mem_rd_rdv = 1'b0;
        #1;
        chk("t5_err_set", 64'(err), 64'd1);

`ifdef HOST_MEM_ARB_PERF_CNT_EN
        // 6: 10 dma reads with 5 stalled cycles
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            dma_rd_read = 1'b1;
            mem_rd_wait = (i % 3 == 2);
        end
        @(negedge clk);
        dma_rd_read = 1'b0; mem_rd_wait = 1'b0;
        #1;
        chk("t6_dma_rd_grant", 64'(dma_rd_gc), 64'd10);
        chk("t6_dma_stall", 64'(dma_stall), 64'd5);
        chk("t6_krn_rd_grant", 64'(krn_rd_gc), 64'd0);
        chk("t6_dma_wr_grant", 64'(dma_wr_gc), 64'd0);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
